// File: rtl/riscv_tag_prop_ex.sv
// EX-stage tag propagation: holds one ID/EX tag record until EX completes, then issues a one-cycle WB tag write.
// Optional `TAG_PROP_STATS_EN adds a saturating counter of tainted (nonzero-tag) writebacks.
module riscv_tag_prop_ex #(
  parameter int ALU_MODE_WIDTH = 2,
  parameter int TAG_WIDTH      = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid_i,
  output logic                      id_ready_o,
  input  logic [ALU_MODE_WIDTH-1:0] mode_i,
  input  logic [TAG_WIDTH-1:0]      rs1_tag_i,
  input  logic [TAG_WIDTH-1:0]      rs2_tag_i,
  input  logic                      use_rs2_i,
  input  logic [TAG_WIDTH-1:0]      rd_old_tag_i,
  input  logic [4:0]                rd_addr_i,
  input  logic                      rd_we_i,
  input  logic                      ex_ready_i,
  input  logic                      flush_i,
  output logic                      wb_tag_we_o,
  output logic [4:0]                wb_tag_addr_o,
  output logic [TAG_WIDTH-1:0]      wb_tag_o,
`ifdef TAG_PROP_STATS_EN
  input  logic                      stats_clr_i,
  output logic [31:0]               tainted_wr_cnt_o,
`endif
  output logic                      busy_o
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  typedef enum logic [ALU_MODE_WIDTH-1:0] {
    MODE_OLD   = ALU_MODE_WIDTH'(0),
    MODE_AND   = ALU_MODE_WIDTH'(1),
    MODE_OR    = ALU_MODE_WIDTH'(2),
    MODE_CLEAR = ALU_MODE_WIDTH'(3)
  } tag_mode_e;

  state_e                r_state;
  state_e                w_state_nxt;
  tag_mode_e             r_mode;
  logic [TAG_WIDTH-1:0]  r_rs1_tag;
  logic [TAG_WIDTH-1:0]  r_rs2_tag;
  logic                  r_use_rs2;
  logic [TAG_WIDTH-1:0]  r_rd_old_tag;
  logic [4:0]            r_rd_addr;
  logic                  r_rd_we;

  logic                  w_accept;
  logic                  w_complete;
  logic                  w_wb_we_nxt;
  logic [TAG_WIDTH-1:0]  w_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Flush outranks completion, but a same-cycle accept still refills the slot.
  always_comb begin
    id_ready_o  = (r_state == ST_EMPTY) | ex_ready_i | flush_i;
    busy_o      = (r_state == ST_FULL);
    w_accept    = id_valid_i & id_ready_o;
    w_complete  = (r_state == ST_FULL) & ex_ready_i & ~flush_i;
    w_wb_we_nxt = w_complete & r_rd_we & (r_rd_addr != 5'd0);
    w_state_nxt = r_state;
    if (w_accept)
      w_state_nxt = ST_FULL;
    else if ((r_state == ST_FULL) && (ex_ready_i || flush_i))
      w_state_nxt = ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode       <= MODE_OLD;
      r_rs1_tag    <= '0;
      r_rs2_tag    <= '0;
      r_use_rs2    <= 1'b0;
      r_rd_old_tag <= '0;
      r_rd_addr    <= '0;
      r_rd_we      <= 1'b0;
    end else if (w_accept) begin
      r_mode       <= tag_mode_e'(mode_i);
      r_rs1_tag    <= rs1_tag_i;
      r_rs2_tag    <= rs2_tag_i;
      r_use_rs2    <= use_rs2_i;
      r_rd_old_tag <= rd_old_tag_i;
      r_rd_addr    <= rd_addr_i;
      r_rd_we      <= rd_we_i;
    end
  end

  always_comb begin
    w_result = '0;
    case (r_mode)
      MODE_OLD:   w_result = r_rd_old_tag;
      MODE_AND:   w_result = r_use_rs2 ? (r_rs1_tag & r_rs2_tag) : r_rs1_tag;
      MODE_OR:    w_result = r_use_rs2 ? (r_rs1_tag | r_rs2_tag) : r_rs1_tag;
      MODE_CLEAR: w_result = '0;
      default:    w_result = '0;
    endcase
  end

  // x0 suppresses only the enable; address and data still follow the completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_tag_we_o   <= 1'b0;
      wb_tag_addr_o <= '0;
      wb_tag_o      <= '0;
    end else begin
      wb_tag_we_o <= w_wb_we_nxt;
      if (w_complete) begin
        wb_tag_addr_o <= r_rd_addr;
        wb_tag_o      <= w_result;
      end
    end
  end

`ifdef TAG_PROP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tainted_wr_cnt_o <= '0;
    else if (stats_clr_i)
      tainted_wr_cnt_o <= '0;
    else if (w_wb_we_nxt && (w_result != '0) && (tainted_wr_cnt_o != '1))
      tainted_wr_cnt_o <= tainted_wr_cnt_o + 32'd1;
  end
`endif

endmodule
